// File: rtl/frame_pkg.sv
// Shared types and default geometry for the frame-buffer read path.
package frame_pkg;

    localparam int DEF_ADDR_WIDTH = 17;
    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_H_RES      = 320;
    localparam int DEF_V_RES      = 240;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int PIX_W          = 12;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } fr_state_t;

    typedef struct packed {
        pixel_t data;
        logic   sof;
        logic   eol;
    } fifo_entry_t;

    function automatic pixel_t rgb_to_pixel(input rgb_t c);
        return {c.r, c.g, c.b};
    endfunction

endpackage

// File: rtl/frame_fifo.sv
// Synchronous FIFO of tagged pixel entries; the head entry is visible combinationally.
module frame_fifo
    import frame_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fifo_entry_t   push_entry,
    input  logic          pop,
    output fifo_entry_t   head,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // a push into a full FIFO is only accepted when the head leaves on the same edge
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame_reader.sv
// Raster-order frame-buffer reader feeding a tagged valid/ready pixel stream.
// Define FRAME_READER_LOOP_EN for continuous multi-frame reading with a stop input.
module frame_reader
    import frame_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int H_RES      = DEF_H_RES,
    parameter int V_RES      = DEF_V_RES,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef FRAME_READER_LOOP_EN
    input  logic                  stop,
`endif
    output logic                  busy,
    output logic                  frame_done,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_we,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic [1:0]            dbg_state
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    fr_state_t             state;
    fr_state_t             state_nxt;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [XW-1:0]         x_cnt;
    logic [YW-1:0]         y_cnt;
    logic [YW-1:0]         pop_y;
    logic                  rd_pending;
    logic                  pend_sof;
    logic                  pend_eol;
    logic                  issue;
    logic                  pop;
    logic                  last_issue;
    logic                  frame_end_pop;
    logic                  stop_req;
    logic [CW:0]           occ_after;
    fifo_entry_t           push_entry;
    fifo_entry_t           head;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;

    // Stream handshake: a beat transfers on a rising edge where m_valid and
    // m_ready are both high; once m_valid rises, m_data/m_sof/m_eol hold
    // until that edge.
    assign m_valid = ~fifo_empty;
    assign pop     = m_valid & m_ready;
    assign m_data  = m_valid ? DATA_WIDTH'(head.data) : '0;
    assign m_sof   = m_valid & head.sof;
    assign m_eol   = m_valid & head.eol;

    assign sram_we   = 1'b0;
    assign sram_din  = '0;
    assign sram_addr = addr_cnt;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Reads already in flight count against FIFO space so a returning word always fits.
    assign occ_after  = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pending} - {{CW{1'b0}}, pop};
    assign issue      = (state == READ) && (occ_after < (CW + 1)'(FIFO_DEPTH));
    assign last_issue = issue && (x_cnt == X_LAST) && (y_cnt == Y_LAST);

    assign frame_end_pop = pop && head.eol && (pop_y == Y_LAST);
    assign frame_done    = frame_end_pop;

    assign push_entry = '{data: pixel_t'(sram_dout), sof: pend_sof, eol: pend_eol};

`ifdef FRAME_READER_LOOP_EN
    logic stop_seen;

    assign stop_req = stop_seen | stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_seen <= 1'b0;
        end else if (state == IDLE) begin
            stop_seen <= 1'b0;
        end else if (state == READ) begin
            if (last_issue) begin
                stop_seen <= 1'b0;
            end else if (stop) begin
                stop_seen <= 1'b1;
            end
        end
    end
`else
    assign stop_req = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (last_issue && stop_req) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (frame_end_pop && !rd_pending && (fifo_count == CW'(1))) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Raster walk; tags are latched at issue so they travel with the returning word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt   <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            rd_pending <= 1'b0;
            pend_sof   <= 1'b0;
            pend_eol   <= 1'b0;
        end else begin
            rd_pending <= issue;
            if (issue) begin
                pend_sof <= (addr_cnt == '0);
                pend_eol <= (x_cnt == X_LAST);
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    if (y_cnt == Y_LAST) begin
                        y_cnt    <= '0;
                        addr_cnt <= '0;
                    end else begin
                        y_cnt    <= y_cnt + 1'b1;
                        addr_cnt <= addr_cnt + 1'b1;
                    end
                end else begin
                    x_cnt    <= x_cnt + 1'b1;
                    addr_cnt <= addr_cnt + 1'b1;
                end
            end
        end
    end

    // Line count on the output side identifies the final pixel of each frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_y <= '0;
        end else if (pop && head.eol) begin
            pop_y <= (pop_y == Y_LAST) ? '0 : pop_y + 1'b1;
        end
    end

    frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (rd_pending),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .empty      (fifo_empty)
    );

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader on a 4x3 frame with a 1-cycle-latency SRAM model.
module tb_frame_reader;

    localparam int AW    = 17;
    localparam int DW    = 12;
    localparam int H     = 4;
    localparam int V     = 3;
    localparam int FD    = 4;
    localparam int TOTAL = H * V;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          frame_done;
    logic [AW-1:0] sram_addr;
    logic          sram_we;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_sof;
    logic          m_eol;
    logic [1:0]    dbg_state;
`ifdef FRAME_READER_LOOP_EN
    logic          stop;
`endif

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int beats     = 0;
    int done_cnt  = 0;
    int first_pop = -1;
    int last_pop  = -1;
    int rdy_mode  = 1;

    // {last_of_frame, sof, eol, data}
    logic [14:0]   exp_q[$];
    logic [DW-1:0] mem [TOTAL];

    frame_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .H_RES      (H),
        .V_RES      (V),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
`ifdef FRAME_READER_LOOP_EN
        .stop       (stop),
`endif
        .busy       (busy),
        .frame_done (frame_done),
        .sram_addr  (sram_addr),
        .sram_we    (sram_we),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // SRAM with one cycle of read latency
    always @(posedge clk) begin
        if (int'(sram_addr) < TOTAL) sram_dout <= mem[int'(sram_addr)];
        else sram_dout <= DW'($urandom);
    end

    // downstream ready driver: 0 = hold low, 1 = hold high, 2 = random
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < TOTAL; i++) mem[i] = DW'($urandom_range(0, 4095));
    endtask

    task automatic expect_frame();
        for (int i = 0; i < TOTAL; i++)
            exp_q.push_back({i == TOTAL - 1, i == 0, (i % H) == H - 1, mem[i]});
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        #1;
        check("busy_after_frame", busy, 0);
        check("idle_after_frame", dbg_state, frame_pkg::IDLE);
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n = 0;
        while (beats < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("beat_wait_timeout", beats, target);
    endtask

    // scoreboard: every presented beat is compared with the head of exp_q
    initial begin
        logic [14:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (frame_done) done_cnt++;
                if (exp_q.size() == 0) begin
                    check("no_extra_beat", m_valid, 0);
                end else if (m_valid) begin
                    e = exp_q[0];
                    check("beat", {m_sof, m_eol, m_data}, 32'(e[13:0]));
                    if (m_ready) begin
                        check("done_on_pop", frame_done, e[14]);
                        if (first_pop < 0) first_pop = cyc;
                        last_pop = cyc;
                        void'(exp_q.pop_front());
                        beats++;
                    end else begin
                        check("fifo_bound", dut.u_fifo.count <= FD, 1);
                    end
                end
                if (!(m_valid && m_ready)) check("done_no_pop", frame_done, 0);
            end
        end
    end

    initial begin
        int d0;
        int b0;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;

        rst_n = 1'b0;
        start = 1'b0;
`ifdef FRAME_READER_LOOP_EN
        stop  = 1'b1;
`endif
        fill_mem();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_sof", m_sof, 0);
        check("rst_m_eol", m_eol, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_m_data", m_data, 0);
        check("rst_sram_we", sram_we, 0);
        check("rst_sram_din", sram_din, 0);
        check("rst_state", dbg_state, frame_pkg::IDLE);
        rst_n = 1'b1;

        // full-rate frame with latency and throughput checks
        expect_frame();
        d0 = done_cnt;
        first_pop = -1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_on_accept", busy, 1);
        check("first_addr", sram_addr, 0);
        check("lat_e0_valid", m_valid, 0);
        @(posedge clk);
        #1 check("lat_e1_valid", m_valid, 0);
        @(posedge clk);
        #1 check("lat_e2_valid", m_valid, 1);
        check("lat_e2_data", m_data, mem[0]);
        check("lat_e2_sof", m_sof, 1);
        wait_drain(200);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_throughput", last_pop - first_pop, TOTAL - 1);

        // random backpressure
        fill_mem();
        expect_frame();
        d0 = done_cnt;
        rdy_mode = 2;
        do_start();
        wait_drain(400);
        rdy_mode = 1;
        check("t2_done_count", done_cnt - d0, 1);

        // held backpressure: issuing must stop once the FIFO is committed
        fill_mem();
        expect_frame();
        d0 = done_cnt;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        do_start();
        repeat (10) @(posedge clk);
        #1 a1 = sram_addr;
        repeat (10) @(posedge clk);
        #1 a2 = sram_addr;
        check("stall_addr_stable", a2, a1);
        check("stall_addr_range", (a2 >= FD - 1) && (a2 <= FD), 1);
        check("stall_fifo_full", dut.u_fifo.count, FD);
        check("stall_busy", busy, 1);
        rdy_mode = 1;
        wait_drain(200);
        check("t3_done_count", done_cnt - d0, 1);

        // asynchronous reset in the middle of a frame
        fill_mem();
        expect_frame();
        d0 = done_cnt;
        b0 = beats;
        do_start();
        wait_beats(b0 + 5, 100);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_sram_addr", sram_addr, 0);
        check("midrst_m_data", m_data, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("midrst_no_done", done_cnt - d0, 0);
        expect_frame();
        do_start();
        wait_drain(200);
        check("t4_done_count", done_cnt - d0, 1);

        // start pulsed again while busy is ignored
        fill_mem();
        expect_frame();
        d0 = done_cnt;
        rdy_mode = 2;
        do_start();
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_drain(400);
        rdy_mode = 1;
        repeat (20) @(posedge clk);
        #1;
        check("t5_done_count", done_cnt - d0, 1);
        check("t5_busy", busy, 0);

`ifdef FRAME_READER_LOOP_EN
        // two back-to-back frames, stop raised during the second
        fill_mem();
        expect_frame();
        expect_frame();
        d0 = done_cnt;
        b0 = beats;
        first_pop = -1;
        stop = 1'b0;
        do_start();
        wait_beats(b0 + TOTAL + 2, 200);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        wait_drain(200);
        check("t6_done_count", done_cnt - d0, 2);
        check("t6_beats", beats - b0, 2 * TOTAL);
        check("t6_throughput", last_pop - first_pop, 2 * TOTAL - 1);
        repeat (20) @(posedge clk);
        #1 check("t6_busy", busy, 0);
        stop = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
